// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time over req/ack,
// and presents each returned word to the decoder through a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  assign target_aligned = redirect_target & ~ADDR_WIDTH'(3);
  // PC to use when the current edge may also carry a redirect
  assign redirect_pc    = redirect ? target_aligned : pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      fetch_count <= '0;
      flush       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc <= redirect_pc;
          if (enable) begin
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!imem_ack) begin
            // Read still in flight: remember the redirect and drop its data later
            if (redirect) begin
              pc    <= target_aligned;
              flush <= 1'b1;
            end
          end else if (!flush && !redirect) begin
            instruction <= imem_data;
            inst_pc     <= imem_addr;
            inst_valid  <= 1'b1;
            pc          <= pc + ADDR_WIDTH'(PC_STEP);
            imem_req    <= 1'b0;
            state       <= HOLD;
          end else begin
            flush <= 1'b0;
            pc    <= redirect_pc;
            if (enable) begin
              imem_addr <= redirect_pc;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            // Squashed instruction is not counted even if accepted this cycle
            inst_valid <= 1'b0;
            pc         <= target_aligned;
            if (enable) begin
              imem_req  <= 1'b1;
              imem_addr <= target_aligned;
              state     <= REQ;
            end else begin
              state <= IDLE;
            end
          end else if (inst_ready) begin
            inst_valid  <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
            if (enable) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
